// File: rtl/vol_pkg.sv
// Shared widths, types and the saturating clamp used by the volatility estimator
// and the downstream spread stage.
package vol_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_DELTA_WIDTH = 16;
    localparam int DEF_LOG2_WINDOW = 4;
    localparam int WINDOW          = 1 << DEF_LOG2_WINDOW;

    typedef logic signed [DEF_DELTA_WIDTH-1:0]                   delta_t;
    typedef logic signed [DEF_DELTA_WIDTH+DEF_LOG2_WINDOW-1:0]   sum_t;
    typedef logic        [2*DEF_DELTA_WIDTH+DEF_LOG2_WINDOW-1:0] sq_sum_t;

    // Callers size-cast the result down; lo/hi must fit the destination width.
    function automatic logic signed [63:0] sat_clamp(
        input logic signed [63:0] x,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        logic signed [63:0] y;
        y = x;
        if (x < lo) begin
            y = lo;
        end else if (x > hi) begin
            y = hi;
        end
        return y;
    endfunction

endpackage

// File: rtl/volatility_estimator_delta_ring_buffer.sv
// Circular store of the last 2^LOG2_WINDOW deltas; returns the delta being evicted,
// forced to zero while the window is still filling.
module delta_ring_buffer
    import vol_pkg::*;
#(
    parameter int DELTA_WIDTH = DEF_DELTA_WIDTH,
    parameter int LOG2_WINDOW = DEF_LOG2_WINDOW
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_push,
    input  logic signed [DELTA_WIDTH-1:0] i_delta,
    output logic signed [DELTA_WIDTH-1:0] o_oldest,
    output logic                          o_window_full
);

    localparam int N      = 1 << LOG2_WINDOW;
    localparam int FILL_W = LOG2_WINDOW + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);

    logic signed [DELTA_WIDTH-1:0] r_mem [N];
    logic        [LOG2_WINDOW-1:0] r_wr_ptr;
    logic        [FILL_W-1:0]      r_fill;
    logic signed [DELTA_WIDTH-1:0] r_oldest;
    logic                          r_window_full;
    logic                          w_full;

    assign w_full        = (r_fill == FILL_FULL);
    assign o_oldest      = r_oldest;
    assign o_window_full = r_window_full;

    // NOTE: the delta store has no reset; stale contents are never observed because
    // the eviction read is gated by the fill count, and leaving it out keeps it a plain RAM.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_delta;
        end
    end

    // The eviction read and the overwrite of the same slot share one edge (read-old-data),
    // so back-to-back pushes never see a half-updated pointer.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr      <= '0;
            r_fill        <= '0;
            r_oldest      <= '0;
            r_window_full <= 1'b0;
        end else if (i_push) begin
            r_oldest      <= w_full ? r_mem[r_wr_ptr] : '0;
            r_window_full <= (r_fill >= FILL_LAST);
            r_wr_ptr      <= r_wr_ptr + LOG2_WINDOW'(1);
            if (!w_full) begin
                r_fill <= r_fill + FILL_W'(1);
            end
        end
    end

endmodule

// File: rtl/volatility_estimator.sv
// Rolling variance of mid-price tick deltas over a 2^LOG2_WINDOW window, feeding the spread stage.
// Define VOL_WARMUP_OUT_EN to emit results (zero-padded window) while the window is still filling.
module volatility_estimator
    import vol_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DELTA_WIDTH = DEF_DELTA_WIDTH,
    parameter int LOG2_WINDOW = DEF_LOG2_WINDOW
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_price,
    input  logic                  i_data_valid,
    output logic [DATA_WIDTH-1:0] o_volatility,
    output logic [DATA_WIDTH-1:0] o_curr_time,
    output logic                  o_data_valid
);

    localparam int SUM_W = DELTA_WIDTH + LOG2_WINDOW;
    localparam int SQ_W  = 2 * DELTA_WIDTH;
    localparam int ACC_W = SQ_W + LOG2_WINDOW;
    localparam logic signed [63:0] DELTA_MAX = (64'sd1 <<< (DELTA_WIDTH - 1)) - 64'sd1;
    localparam logic signed [63:0] DELTA_MIN = -(64'sd1 <<< (DELTA_WIDTH - 1));
    localparam logic signed [63:0] VAR_MAX   = (64'sd1 <<< DATA_WIDTH) - 64'sd1;

    logic [DATA_WIDTH-1:0]         r_prev_price;
    logic                          r_prev_valid;
    logic                          w_push;
    logic signed [DATA_WIDTH:0]    w_diff;
    logic signed [DELTA_WIDTH-1:0] w_delta;
    logic signed [DELTA_WIDTH-1:0] r_s1_delta;
    logic                          r_s1_valid;
    logic signed [DELTA_WIDTH-1:0] w_oldest;
    logic                          w_window_full;
    logic signed [SQ_W-1:0]        w_d_ext, w_o_ext, w_d_sq, w_o_sq;
    logic signed [SUM_W-1:0]       r_sum;
    logic        [ACC_W-1:0]       r_sq_sum;
    logic        [DATA_WIDTH-1:0]  r_count;
    logic                          r_s2_valid;
    logic                          w_s2_emit;
    logic signed [SUM_W-1:0]       w_mean;
    logic signed [63:0]            w_mean_64, w_var;
    logic        [DATA_WIDTH-1:0]  r_volatility, r_curr_time;
    logic                          r_data_valid;

    // Stage 1: delta against the previous price; the very first sample only primes.
    assign w_push  = i_data_valid && r_prev_valid;
    assign w_diff  = $signed({1'b0, i_price}) - $signed({1'b0, r_prev_price});
    assign w_delta = DELTA_WIDTH'(sat_clamp(64'(w_diff), DELTA_MIN, DELTA_MAX));

    // NOTE: every clocked process uses <= so each stage reads the previous stage's
    // pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_prev_valid <= 1'b0;
            r_prev_price <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_delta   <= '0;
        end else begin
            r_s1_valid <= w_push;
            if (i_data_valid) begin
                r_prev_valid <= 1'b1;
                r_prev_price <= i_price;
            end
            if (w_push) begin
                r_s1_delta <= w_delta;
            end
        end
    end

    delta_ring_buffer #(
        .DELTA_WIDTH (DELTA_WIDTH),
        .LOG2_WINDOW (LOG2_WINDOW)
    ) u_ring (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_push        (w_push),
        .i_delta       (w_delta),
        .o_oldest      (w_oldest),
        .o_window_full (w_window_full)
    );

    // Stage 2: incremental window sums.
    assign w_d_ext = SQ_W'(r_s1_delta);
    assign w_o_ext = SQ_W'(w_oldest);
    assign w_d_sq  = w_d_ext * w_d_ext;
    assign w_o_sq  = w_o_ext * w_o_ext;

`ifdef VOL_WARMUP_OUT_EN
    assign w_s2_emit = r_s1_valid;
`else
    assign w_s2_emit = r_s1_valid && w_window_full;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sum      <= '0;
            r_sq_sum   <= '0;
            r_count    <= '0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_valid <= w_s2_emit;
            if (r_s1_valid) begin
                r_sum    <= r_sum + SUM_W'(r_s1_delta) - SUM_W'(w_oldest);
                r_sq_sum <= r_sq_sum + ACC_W'($unsigned(w_d_sq)) - ACC_W'($unsigned(w_o_sq));
                if (r_count != '1) begin
                    r_count <= r_count + DATA_WIDTH'(1);
                end
            end
        end
    end

    // Stage 3: var = E[d^2] - E[d]^2 with floor-rounded means, clamped into the output range.
    assign w_mean    = r_sum >>> LOG2_WINDOW;
    assign w_mean_64 = 64'(w_mean);
    assign w_var     = $signed(64'(r_sq_sum >> LOG2_WINDOW)) - w_mean_64 * w_mean_64;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_volatility <= '0;
            r_curr_time  <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_volatility <= DATA_WIDTH'(sat_clamp(w_var, 64'sd0, VAR_MAX));
                r_curr_time  <= r_count;
            end
        end
    end

    assign o_volatility = r_volatility;
    assign o_curr_time  = r_curr_time;
    assign o_data_valid = r_data_valid;

endmodule
